data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 48 ++++
 rtl/data_mem_responder_align.sv | 37 +++
 rtl/data_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared constants for the data-memory responder: access-size encodings,
// controller state encoding, and small helpers for alignment and lane
// enables. The memory word is four little-endian byte lanes.
// ----------------------------------------------------------------------------
package data_mem_responder_pkg;

   localparam int unsigned LANES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Reserved size is always an error; halves need an even address, words
   // need a word-aligned address.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte-lane write enables for an aligned store.
   function automatic logic [LANES-1:0] byte_en(input logic [1:0] size,
                                                input logic [1:0] off);
      logic [LANES-1:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/data_mem_responder_align.sv
// ----------------------------------------------------------------------------
// data_load_align
// Purely combinational load alignment: picks the addressed byte or half-word
// out of a memory word and sign- or zero-extends it to LEN bits.
//   i_word     : full memory word (little-endian lanes)
//   i_off      : byte offset within the word (i_addr[1:0])
//   i_size     : access size encoding
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : extended load data (0 for the reserved size)
// ----------------------------------------------------------------------------
module data_load_align
   import data_mem_responder_pkg::*;
#(
   parameter int LEN = 32
) (
   input  logic [LEN-1:0] i_word,
   input  logic [1:0]     i_off,
   input  logic [1:0]     i_size,
   input  logic           i_unsigned,
   output logic [LEN-1:0] o_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = i_word[{i_off, 3'b000} +: 8];
      half_sel = i_off[1] ? i_word[31:16] : i_word[15:0];
      case (i_size)
         SZ_BYTE: o_data = {{(LEN-8){~i_unsigned & byte_sel[7]}}, byte_sel};
         SZ_HALF: o_data = {{(LEN-16){~i_unsigned & half_sel[15]}}, half_sel};
         SZ_WORD: o_data = i_word;
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Single-port data memory for the pipeline's memory-access stage, with a
// debug read port that takes over while the core is halted.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_mem_read / i_mem_write  : load / store request (store wins if both)
//   i_size, i_unsigned        : access size and load extension mode
//   i_addr, i_wdata           : byte address, right-justified store data
//   o_rdata, o_rvalid         : load result, valid one cycle after request
//   o_misaligned              : one-cycle pulse for an illegal access
//   o_ready                   : high once the memory accepts requests
//   i_dbg_halt, i_dbg_rd,
//   i_dbg_addr                : debug ownership, word read, word index
//   o_dbg_data, o_dbg_valid   : debug read result, valid one cycle later
// After reset the controller sweeps zeros into every word before becoming
// ready. With a non-empty INIT_FILE the array contents are supplied by the
// implementation's memory-initialisation flow and the sweep is skipped.
// ----------------------------------------------------------------------------
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int    LEN       = 32,
   parameter int    RAM_DEPTH = 2048,
   parameter int    NB_WADDR  = 11,
   parameter string INIT_FILE = ""
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_mem_read,
   input  logic                i_mem_write,
   input  logic [1:0]          i_size,
   input  logic                i_unsigned,
   input  logic [LEN-1:0]      i_addr,
   input  logic [LEN-1:0]      i_wdata,
   output logic [LEN-1:0]      o_rdata,
   output logic                o_rvalid,
   output logic                o_misaligned,
   output logic                o_ready,
   input  logic                i_dbg_halt,
   input  logic                i_dbg_rd,
   input  logic [NB_WADDR-1:0] i_dbg_addr,
   output logic [LEN-1:0]      o_dbg_data,
   output logic                o_dbg_valid
);

   localparam bit PRELOAD = (INIT_FILE != "");

   logic [LEN-1:0] mem [RAM_DEPTH];

   state_e              state_q, state_d;
   logic [NB_WADDR-1:0] sweep_q, sweep_d;
   logic [LEN-1:0]      rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;
   logic                misal_q, misal_d;
   logic [LEN-1:0]      dbg_data_q, dbg_data_d;
   logic                dbg_valid_q, dbg_valid_d;

   logic [NB_WADDR-1:0] widx;
   logic [1:0]          off;
   logic                accept, st_req, ld_req, bad, we;
   logic [LANES-1:0]    be;
   logic [LEN-1:0]      wd_lanes;
   logic [LEN-1:0]      ld_data;
   logic                unused_addr;

   // Upper address bits are ignored so the address space wraps.
   assign widx        = i_addr[NB_WADDR+1:2];
   assign off         = i_addr[1:0];
   assign unused_addr = ^i_addr[LEN-1:NB_WADDR+2];

   // Pipeline requests are only seen when ready and not halted; a combined
   // read+write is a store only.
   assign accept = (state_q == ST_READY) && !i_dbg_halt;
   assign st_req = accept && i_mem_write;
   assign ld_req = accept && i_mem_read && !i_mem_write;
   assign bad    = is_misaligned(i_size, off);
   assign we     = st_req && !bad;
   assign be     = byte_en(i_size, off);

   always_comb begin
      case (i_size)
         SZ_BYTE: wd_lanes = {LANES{i_wdata[7:0]}};
         SZ_HALF: wd_lanes = {(LANES/2){i_wdata[15:0]}};
         default: wd_lanes = i_wdata;
      endcase
   end

   data_load_align #(.LEN(LEN)) u_align (
      .i_word     (mem[widx]),
      .i_off      (off),
      .i_size     (i_size),
      .i_unsigned (i_unsigned),
      .o_data     (ld_data)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= PRELOAD ? ST_READY : ST_CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      if (state_q == ST_CLEAR) begin
         sweep_d = sweep_q + 1'b1;
         if (sweep_q == NB_WADDR'(RAM_DEPTH - 1)) state_d = ST_READY;
      end
   end

   // Output logic; o_ready is forced low while reset is held, which matters
   // when the preload path parks the FSM in READY during reset.
   always_comb begin
      o_ready = (state_q == ST_READY) && !i_rst;
   end

   // Response computation: misaligned accesses report an error with zeroed
   // data, good loads capture the aligned lane(s), otherwise data is held.
   always_comb begin
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;
      misal_d     = 1'b0;
      dbg_data_d  = dbg_data_q;
      dbg_valid_d = 1'b0;
      if ((st_req || ld_req) && bad) begin
         misal_d = 1'b1;
         rdata_d = '0;
      end else if (ld_req) begin
         rvalid_d = 1'b1;
         rdata_d  = ld_data;
      end
      if ((state_q == ST_READY) && i_dbg_halt && i_dbg_rd) begin
         dbg_valid_d = 1'b1;
         dbg_data_d  = mem[i_dbg_addr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         misal_q     <= 1'b0;
         dbg_data_q  <= '0;
         dbg_valid_q <= 1'b0;
      end else begin
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         misal_q     <= misal_d;
         dbg_data_q  <= dbg_data_d;
         dbg_valid_q <= dbg_valid_d;
      end
   end

   // Memory array: clearing sweep or byte-enabled store.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (state_q == ST_CLEAR) begin
            mem[sweep_q] <= '0;
         end else if (we) begin
            for (int b = 0; b < LANES; b++) begin
               if (be[b]) mem[widx][8*b +: 8] <= wd_lanes[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata      = rdata_q;
   assign o_rvalid     = rvalid_q;
   assign o_misaligned = misal_q;
   assign o_dbg_data   = dbg_data_q;
   assign o_dbg_valid  = dbg_valid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder with default parameters: reset and
// clearing sweep, sized loads/stores, misaligned accesses, combined
// read+write, debug port and reset during the sweep.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic        i_mem_read = 1'b0, i_mem_write = 1'b0;
   logic [1:0]  i_size = 2'b00;
   logic        i_unsigned = 1'b0;
   logic [31:0] i_addr = '0, i_wdata = '0;
   logic [31:0] o_rdata;
   logic        o_rvalid, o_misaligned, o_ready;
   logic        i_dbg_halt = 1'b0, i_dbg_rd = 1'b0;
   logic [10:0] i_dbg_addr = '0;
   logic [31:0] o_dbg_data;
   logic        o_dbg_valid;

   int checks = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   data_mem_responder dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
      .i_size(i_size), .i_unsigned(i_unsigned),
      .i_addr(i_addr), .i_wdata(i_wdata),
      .o_rdata(o_rdata), .o_rvalid(o_rvalid),
      .o_misaligned(o_misaligned), .o_ready(o_ready),
      .i_dbg_halt(i_dbg_halt), .i_dbg_rd(i_dbg_rd), .i_dbg_addr(i_dbg_addr),
      .o_dbg_data(o_dbg_data), .o_dbg_valid(o_dbg_valid)
   );

   // One request cycle; returns sampled just after the capturing edge.
   task automatic req(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr,
                      input logic [31:0] wdata);
      @(negedge i_clk);
      i_mem_read = rd; i_mem_write = wr; i_size = sz;
      i_unsigned = uns; i_addr = addr; i_wdata = wdata;
      @(posedge i_clk); #1;
      i_mem_read = 1'b0; i_mem_write = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge i_clk); #1;
   endtask

   // Count cycles from reset release until o_ready rises (bounded).
   task automatic wait_ready(input string name);
      int  n = 0;
      bit  seen = 0;
      while (n < 3000 && !seen) begin
         @(posedge i_clk); #1;
         n++;
         if (o_ready) seen = 1;
      end
      checks++;
      if (!seen || n != 2048) begin
         failures++;
         $display("FAIL %s: o_ready after %0d cycles (seen=%0d), required 2048", name, n, seen);
      end
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      i_rst = 1'b1; i_mem_read = 1'b1; i_size = SZ_WORD; i_addr = 32'h0;
      repeat (3) @(posedge i_clk);
      #1;
      checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b, required 0", o_rvalid); end
      checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h, required 0", o_rdata); end
      checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL rst_misal: got %b, required 0", o_misaligned); end
      checks++; if (o_dbg_valid !== 1'b0) begin failures++; $display("FAIL rst_dbg_valid: got %b, required 0", o_dbg_valid); end
      checks++; if (o_dbg_data !== 32'h0) begin failures++; $display("FAIL rst_dbg_data: got %h, required 0", o_dbg_data); end
      checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b, required 0", o_ready); end
      @(negedge i_clk);
      i_rst = 1'b0; i_mem_read = 1'b0;
      wait_ready("sweep_len");
   endtask

   task automatic test_clear_contents();
      logic [31:0] addrs [3];
      addrs[0] = 32'h0000_0000; addrs[1] = 32'h0000_1FFC; addrs[2] = 32'h0000_07FC;
      for (int i = 0; i < 3; i++) begin
         req(1, 0, SZ_WORD, 0, addrs[i], 32'h0);
         checks++;
         if (o_rvalid !== 1'b1 || o_rdata !== 32'h0) begin
            failures++;
            $display("FAIL clear_read[%0d]: rvalid=%b rdata=%h, required 1/00000000", i, o_rvalid, o_rdata);
         end
      end
   endtask

   task automatic test_store_load();
      req(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF);
      checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL sw_no_rvalid: got %b, required 0", o_rvalid); end
      req(1, 0, SZ_BYTE, 0, 32'h13, 32'h0);
      checks++; if (o_rvalid !== 1'b1 || o_rdata !== 32'hFFFFFFDE) begin failures++; $display("FAIL lb_13: rvalid=%b rdata=%h, required 1/ffffffde", o_rvalid, o_rdata); end
      req(1, 0, SZ_BYTE, 1, 32'h13, 32'h0);
      checks++; if (o_rdata !== 32'h000000DE) begin failures++; $display("FAIL lbu_13: got %h, required 000000de", o_rdata); end
      req(1, 0, SZ_HALF, 0, 32'h10, 32'h0);
      checks++; if (o_rdata !== 32'hFFFFBEEF) begin failures++; $display("FAIL lh_10: got %h, required ffffbeef", o_rdata); end
      req(1, 0, SZ_HALF, 1, 32'h12, 32'h0);
      checks++; if (o_rdata !== 32'h0000DEAD) begin failures++; $display("FAIL lhu_12: got %h, required 0000dead", o_rdata); end
      req(1, 0, SZ_WORD, 0, 32'h2010, 32'h0);
      checks++; if (o_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_wrap: got %h, required deadbeef", o_rdata); end
   endtask

   task automatic test_byte_store();
      req(0, 1, SZ_BYTE, 0, 32'h21, 32'h0000007F);
      req(1, 0, SZ_WORD, 0, 32'h20, 32'h0);
      checks++; if (o_rvalid !== 1'b1 || o_rdata !== 32'h00007F00) begin failures++; $display("FAIL lw_20: rvalid=%b rdata=%h, required 1/00007f00", o_rvalid, o_rdata); end
      idle_cycle();
      checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse: got %b, required 0", o_rvalid); end
      checks++; if (o_rdata !== 32'h00007F00) begin failures++; $display("FAIL rdata_hold: got %h, required 00007f00", o_rdata); end
   endtask

   task automatic test_misaligned();
      req(0, 1, SZ_WORD, 0, 32'h30, 32'h11223344);
      req(1, 0, SZ_WORD, 0, 32'h30, 32'h0);
      checks++; if (o_rdata !== 32'h11223344) begin failures++; $display("FAIL lw_30: got %h, required 11223344", o_rdata); end
      req(1, 0, SZ_WORD, 0, 32'h22, 32'h0);
      checks++; if (o_misaligned !== 1'b1 || o_rvalid !== 1'b0 || o_rdata !== 32'h0) begin failures++; $display("FAIL lw_22: misal=%b rvalid=%b rdata=%h, required 1/0/00000000", o_misaligned, o_rvalid, o_rdata); end
      req(0, 1, SZ_HALF, 0, 32'h31, 32'h0000AAAA);
      checks++; if (o_misaligned !== 1'b1) begin failures++; $display("FAIL sh_31_misal: got %b, required 1", o_misaligned); end
      req(1, 0, SZ_RSVD, 0, 32'h30, 32'h0);
      checks++; if (o_misaligned !== 1'b1 || o_rvalid !== 1'b0) begin failures++; $display("FAIL size11: misal=%b rvalid=%b, required 1/0", o_misaligned, o_rvalid); end
      req(1, 0, SZ_WORD, 0, 32'h30, 32'h0);
      checks++; if (o_rdata !== 32'h11223344 || o_misaligned !== 1'b0) begin failures++; $display("FAIL lw_30_after: rdata=%h misal=%b, required 11223344/0", o_rdata, o_misaligned); end
      req(1, 0, SZ_HALF, 0, 32'h32, 32'h0);
      checks++; if (o_rdata !== 32'h00001122) begin failures++; $display("FAIL lh_32: got %h, required 00001122", o_rdata); end
      req(0, 1, SZ_HALF, 0, 32'h32, 32'h0000BEEF);
      req(1, 0, SZ_WORD, 0, 32'h30, 32'h0);
      checks++; if (o_rdata !== 32'hBEEF3344) begin failures++; $display("FAIL sh_32: got %h, required beef3344", o_rdata); end
   endtask

   task automatic test_rw_both();
      req(1, 1, SZ_WORD, 0, 32'h8, 32'h00000055);
      checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL rw_no_rvalid: got %b, required 0", o_rvalid); end
      req(1, 0, SZ_WORD, 0, 32'h8, 32'h0);
      checks++; if (o_rvalid !== 1'b1 || o_rdata !== 32'h00000055) begin failures++; $display("FAIL rw_then_lw: rvalid=%b rdata=%h, required 1/00000055", o_rvalid, o_rdata); end
   endtask

   task automatic test_debug();
      req(0, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D);
      @(negedge i_clk);
      i_dbg_halt = 1'b1; i_mem_write = 1'b1; i_size = SZ_WORD; i_addr = 32'h40; i_wdata = 32'h1;
      @(posedge i_clk); #1;
      i_mem_write = 1'b0;
      @(negedge i_clk);
      i_dbg_rd = 1'b1; i_dbg_addr = 11'd16; i_mem_read = 1'b1; i_addr = 32'h40;
      @(posedge i_clk); #1;
      i_dbg_rd = 1'b0; i_mem_read = 1'b0;
      checks++; if (o_dbg_valid !== 1'b1 || o_dbg_data !== 32'hCAFEF00D) begin failures++; $display("FAIL dbg_read: valid=%b data=%h, required 1/cafef00d", o_dbg_valid, o_dbg_data); end
      checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL halt_blocks_load: rvalid=%b, required 0", o_rvalid); end
      idle_cycle();
      checks++; if (o_dbg_valid !== 1'b0 || o_dbg_data !== 32'hCAFEF00D) begin failures++; $display("FAIL dbg_hold: valid=%b data=%h, required 0/cafef00d", o_dbg_valid, o_dbg_data); end
      @(negedge i_clk);
      i_dbg_halt = 1'b0; i_dbg_rd = 1'b1; i_dbg_addr = 11'd2;
      @(posedge i_clk); #1;
      i_dbg_rd = 1'b0;
      checks++; if (o_dbg_valid !== 1'b0) begin failures++; $display("FAIL dbg_no_halt: valid=%b, required 0", o_dbg_valid); end
      req(1, 0, SZ_WORD, 0, 32'h40, 32'h0);
      checks++; if (o_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL halt_no_write: got %h, required cafef00d", o_rdata); end
   endtask

   task automatic test_reset_mid_sweep();
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      @(negedge i_clk);
      i_rst = 1'b0;
      req(1, 0, SZ_WORD, 0, 32'h0, 32'h0);
      checks++; if (o_rvalid !== 1'b0) begin failures++; $display("FAIL clear_ignore_ld: rvalid=%b, required 0", o_rvalid); end
      req(1, 0, SZ_WORD, 0, 32'h22, 32'h0);
      checks++; if (o_misaligned !== 1'b0) begin failures++; $display("FAIL clear_ignore_misal: got %b, required 0", o_misaligned); end
      @(negedge i_clk);
      i_dbg_halt = 1'b1; i_dbg_rd = 1'b1; i_dbg_addr = 11'd0;
      @(posedge i_clk); #1;
      i_dbg_halt = 1'b0; i_dbg_rd = 1'b0;
      checks++; if (o_dbg_valid !== 1'b0) begin failures++; $display("FAIL clear_ignore_dbg: got %b, required 0", o_dbg_valid); end
      repeat (97) @(posedge i_clk);
      #1;
      checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL mid_sweep_ready: got %b, required 0", o_ready); end
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      @(negedge i_clk);
      i_rst = 1'b0;
      wait_ready("sweep_restart");
      req(1, 0, SZ_WORD, 0, 32'h10, 32'h0);
      checks++; if (o_rvalid !== 1'b1 || o_rdata !== 32'h0) begin failures++; $display("FAIL cleared_after_reset: rvalid=%b rdata=%h, required 1/00000000", o_rvalid, o_rdata); end
   endtask

   initial begin
      test_reset();
      test_clear_contents();
      test_store_load();
      test_byte_store();
      test_misaligned();
      test_rw_both();
      test_debug();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
